ifu_redirect_ctrl: RTL and testbench
====================================

// Module: ifu_redirect_ctrl
// PURPOSE
//  Sequences every PC redirect in the IFU. Arbitrates trap, mret, branch-mispredict and fence.i
//  redirect requests and drives the PC register's jump_flag/jump_addr/hold_flag inputs.
//  Holds a redirect stable until the fetch bus accepts it, then flushes in-flight fetches.
//  Sits between EXU/CSR (requesters) and the PC register / IF stage.
// PARAMETERS
//  ADDR_W     32  instruction address width
//  HOLD_W     3   hold-flag bus width (levels: 0 none, 1 PC, 2 IF, 3 ID)
//  DRAIN_CYC  2   flush cycles after an accepted redirect (0 = no DRAIN state)
// PORTS
//  clk            in   1       clock
//  rst            in   1       reset, synchronous, active-high
//  trap_req_i     in   1       trap/interrupt redirect pulse (priority 0, highest)
//  trap_addr_i    in   ADDR_W  trap target
//  mret_req_i     in   1       mret redirect pulse (priority 1)
//  mret_addr_i    in   ADDR_W  mret target
//  br_req_i       in   1       branch/jump mispredict pulse (priority 2)
//  br_addr_i      in   ADDR_W  branch target
//  fencei_req_i   in   1       fence.i refetch pulse (priority 3, lowest)
//  fencei_addr_i  in   ADDR_W  refetch address
//  stall_req_i    in   HOLD_W  hazard hold level from downstream
//  ifu_ready_i    in   1       fetch bus accepts a new address this cycle
//  jump_flag_o    out  1       redirect valid to PC register
//  jump_addr_o    out  ADDR_W  redirect target, bits [1:0] forced 0
//  hold_flag_o    out  HOLD_W  hold level to PC register / pipeline
//  flush_o        out  1       discard in-flight fetch responses
//  src_o          out  2       source of current/last redirect (0 trap .. 3 fence.i)
//  busy_o         out  1       state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, jump_flag_o=0, jump_addr_o=0, flush_o=0, src_o=0, drain counter 0.
//  - Requests are 1-cycle pulses, sampled at posedge; outputs registered; latency 1 cycle.
//  - Multiple simultaneous requests: lowest priority index wins; losers are dropped.
//  - IDLE: any request -> ISSUE, latch winner addr/src, jump_flag_o=1 next cycle.
//  - ISSUE: jump_flag_o/jump_addr_o held stable while ifu_ready_i=0.
//    Request of strictly higher priority than src_o replaces addr/src (stays ISSUE);
//    equal or lower priority request dropped.
//    ifu_ready_i=1 -> redirect accepted: jump_flag_o=0 next cycle; -> DRAIN (DRAIN_CYC>0) else IDLE.
//    Acceptance and higher-priority request in same cycle: new request wins, re-enter ISSUE.
//  - DRAIN: flush_o=1, counter loads DRAIN_CYC-1 on entry, decrements; at 0 -> IDLE.
//    trap/mret request in DRAIN -> ISSUE immediately (flush_o drops), br/fence.i dropped.
//  - hold_flag_o = stall_req_i (combinational) in IDLE/DRAIN; in ISSUE = max(stall_req_i, 1),
//    forcing PC hold while the redirect is pending.
//  - Reset mid-ISSUE/DRAIN: return to IDLE next edge, pending redirect discarded.
// CONFIGURATION
//  REDIRECT_PERF_EN defined: four 32-bit saturating counters, one per source, increment on
//    each accepted redirect (ISSUE with ifu_ready_i=1); output perf_redirect_cnt_o[127:0]
//    ({fencei,br,mret,trap}); cleared by rst.
//  Undefined: counters and perf_redirect_cnt_o port absent; behaviour otherwise identical.
// STRUCTURE
//  Shared defines: source codes (REDIR_TRAP..REDIR_FENCEI), hold levels (Hold_None/Pc/If/Id),
//    state encoding (RDR_IDLE/ISSUE/DRAIN).
//  Sub-module ifu_redirect_prio: combinational 4-way fixed-priority select -> req, src, addr.
// TESTING
//  1 br_req_i=1, br_addr_i=0x100, ifu_ready_i=1 -> next cycle jump_flag_o=1, addr 0x100, src 2;
//    then flush_o=1 for 2 cycles, busy_o back to 0.
//  2 trap_req_i + br_req_i same cycle (0x80 / 0x200) -> jump_addr_o=0x80, src_o=0, br dropped.
//  3 br to 0x300, ifu_ready_i=0 for 3 cycles -> jump_flag_o held, addr 0x300, hold_flag_o>=1;
//    mret_req_i (0x400) mid-wait -> addr becomes 0x400, src 1.
//  4 during DRAIN: fencei_req_i ignored; trap_req_i (0x80) -> ISSUE next cycle, flush_o=0.
//  5 rst asserted in ISSUE -> next cycle jump_flag_o=0, busy_o=0, no redirect issued.
//  6 br_addr_i=0x103 -> jump_addr_o=0x100; with REDIRECT_PERF_EN, 3 accepted br -> cnt[2]=3.

Source files
------------

// File: rtl/ifu_redirect_ctrl_pkg.sv
// Shared types for the IFU redirect sequencer: source codes, hold levels, state encoding.
package ifu_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    REDIR_TRAP   = 2'd0,
    REDIR_MRET   = 2'd1,
    REDIR_BR     = 2'd2,
    REDIR_FENCEI = 2'd3
  } redir_src_e;

  typedef enum logic [1:0] {
    Hold_None = 2'd0,
    Hold_Pc   = 2'd1,
    Hold_If   = 2'd2,
    Hold_Id   = 2'd3
  } hold_e;

  typedef enum logic [1:0] {
    RDR_IDLE  = 2'd0,
    RDR_ISSUE = 2'd1,
    RDR_DRAIN = 2'd2
  } rdr_state_e;

  // Lower source code means higher priority.
  function automatic logic outranks(redir_src_e a, redir_src_e b);
    return a < b;
  endfunction

endpackage

// File: rtl/ifu_redirect_prio.sv
// Combinational fixed-priority select over the four redirect requesters (trap highest).
module ifu_redirect_prio
  import ifu_redirect_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              mret_req_i,
  input  logic [ADDR_W-1:0] mret_addr_i,
  input  logic              br_req_i,
  input  logic [ADDR_W-1:0] br_addr_i,
  input  logic              fencei_req_i,
  input  logic [ADDR_W-1:0] fencei_addr_i,
  output logic              req_o,
  output redir_src_e        src_o,
  output logic [ADDR_W-1:0] addr_o
);

  always_comb begin
    req_o  = 1'b0;
    src_o  = REDIR_TRAP;
    addr_o = '0;
    if (trap_req_i) begin
      req_o  = 1'b1;
      src_o  = REDIR_TRAP;
      addr_o = trap_addr_i;
    end else if (mret_req_i) begin
      req_o  = 1'b1;
      src_o  = REDIR_MRET;
      addr_o = mret_addr_i;
    end else if (br_req_i) begin
      req_o  = 1'b1;
      src_o  = REDIR_BR;
      addr_o = br_addr_i;
    end else if (fencei_req_i) begin
      req_o  = 1'b1;
      src_o  = REDIR_FENCEI;
      addr_o = fencei_addr_i;
    end
  end

endmodule

// File: rtl/ifu_redirect_ctrl.sv
// IFU redirect sequencer: arbitrates redirect sources, holds until fetch accepts, then drains.
// Optional per-source accepted-redirect counters when REDIRECT_PERF_EN is defined.
module ifu_redirect_ctrl
  import ifu_redirect_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned HOLD_W    = 3,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              mret_req_i,
  input  logic [ADDR_W-1:0] mret_addr_i,
  input  logic              br_req_i,
  input  logic [ADDR_W-1:0] br_addr_i,
  input  logic              fencei_req_i,
  input  logic [ADDR_W-1:0] fencei_addr_i,
  input  logic [HOLD_W-1:0] stall_req_i,
  input  logic              ifu_ready_i,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic [HOLD_W-1:0] hold_flag_o,
  output logic              flush_o,
  output logic [1:0]        src_o,
  output logic              busy_o
`ifdef REDIRECT_PERF_EN
  ,
  output logic [127:0]      perf_redirect_cnt_o
`endif
);

  localparam int unsigned CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  rdr_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flag_q, flag_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  redir_src_e        src_q, src_d;

  logic              win_req;
  redir_src_e        win_src;
  logic [ADDR_W-1:0] win_addr;
  logic [ADDR_W-1:0] win_addr_al;
  logic              preempt;
  logic              drain_take;
  logic              accept;

  ifu_redirect_prio #(
    .ADDR_W(ADDR_W)
  ) u_prio (
    .trap_req_i   (trap_req_i),
    .trap_addr_i  (trap_addr_i),
    .mret_req_i   (mret_req_i),
    .mret_addr_i  (mret_addr_i),
    .br_req_i     (br_req_i),
    .br_addr_i    (br_addr_i),
    .fencei_req_i (fencei_req_i),
    .fencei_addr_i(fencei_addr_i),
    .req_o        (win_req),
    .src_o        (win_src),
    .addr_o       (win_addr)
  );

  assign win_addr_al = {win_addr[ADDR_W-1:2], 2'b00};
  assign preempt     = win_req && outranks(win_src, src_q);
  // Only trap/mret may cut a drain short; br/fence.i are dropped while flushing.
  assign drain_take  = win_req && (win_src == REDIR_TRAP || win_src == REDIR_MRET);
  assign accept      = (state_q == RDR_ISSUE) && ifu_ready_i && !preempt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    flush_d = flush_q;
    addr_d  = addr_q;
    src_d   = src_q;
    case (state_q)
      RDR_IDLE: begin
        if (win_req) begin
          state_d = RDR_ISSUE;
          flag_d  = 1'b1;
          addr_d  = win_addr_al;
          src_d   = win_src;
        end
      end
      RDR_ISSUE: begin
        if (preempt) begin
          addr_d = win_addr_al;
          src_d  = win_src;
        end else if (ifu_ready_i) begin
          flag_d = 1'b0;
          if (DRAIN_CYC > 0) begin
            state_d = RDR_DRAIN;
            flush_d = 1'b1;
            cnt_d   = CNT_W'(DRAIN_CYC - 1);
          end else begin
            state_d = RDR_IDLE;
          end
        end
      end
      RDR_DRAIN: begin
        if (drain_take) begin
          state_d = RDR_ISSUE;
          flag_d  = 1'b1;
          flush_d = 1'b0;
          cnt_d   = '0;
          addr_d  = win_addr_al;
          src_d   = win_src;
        end else if (cnt_q == '0) begin
          state_d = RDR_IDLE;
          flush_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = RDR_IDLE;
        flag_d  = 1'b0;
        flush_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RDR_IDLE;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      flush_q <= 1'b0;
      addr_q  <= '0;
      src_q   <= REDIR_TRAP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      flush_q <= flush_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
    end
  end

  // A pending redirect must freeze the PC even if downstream asks for no hold.
  always_comb begin
    hold_flag_o = stall_req_i;
    if (state_q == RDR_ISSUE && stall_req_i < HOLD_W'(Hold_Pc)) begin
      hold_flag_o = HOLD_W'(Hold_Pc);
    end
  end

  assign jump_flag_o = flag_q;
  assign jump_addr_o = addr_q;
  assign flush_o     = flush_q;
  assign src_o       = src_q;
  assign busy_o      = (state_q != RDR_IDLE);

`ifdef REDIRECT_PERF_EN
  logic [31:0] perf_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) perf_q[i] <= '0;
    end else if (accept && perf_q[src_q] != '1) begin
      perf_q[src_q] <= perf_q[src_q] + 32'd1;
    end
  end

  assign perf_redirect_cnt_o = {perf_q[3], perf_q[2], perf_q[1], perf_q[0]};
`endif

endmodule

// File: tb/tb_ifu_redirect_ctrl.sv
// Bench for ifu_redirect_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_ifu_redirect_ctrl;

  localparam int DRAIN_CYC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_req, mret_req, br_req, fencei_req;
  logic [31:0] trap_addr, mret_addr, br_addr, fencei_addr;
  logic [2:0]  stall;
  logic        ready;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic [2:0]  hold_flag;
  logic        flush;
  logic [1:0]  src;
  logic        busy;
`ifdef REDIRECT_PERF_EN
  logic [127:0] perf;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Behavioural model: a pending redirect, remaining flush cycles, per-source accept counts.
  bit          m_pend;
  int          m_drain;
  logic [31:0] m_addr;
  int          m_src;
  longint      m_cnt [4];

  ifu_redirect_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .trap_req_i   (trap_req),
    .trap_addr_i  (trap_addr),
    .mret_req_i   (mret_req),
    .mret_addr_i  (mret_addr),
    .br_req_i     (br_req),
    .br_addr_i    (br_addr),
    .fencei_req_i (fencei_req),
    .fencei_addr_i(fencei_addr),
    .stall_req_i  (stall),
    .ifu_ready_i  (ready),
    .jump_flag_o  (jump_flag),
    .jump_addr_o  (jump_addr),
    .hold_flag_o  (hold_flag),
    .flush_o      (flush),
    .src_o        (src),
    .busy_o       (busy)
`ifdef REDIRECT_PERF_EN
    ,
    .perf_redirect_cnt_o(perf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int w;
    logic [31:0] wa;
    w  = -1;
    wa = '0;
    if (trap_req) begin w = 0; wa = trap_addr; end
    else if (mret_req) begin w = 1; wa = mret_addr; end
    else if (br_req) begin w = 2; wa = br_addr; end
    else if (fencei_req) begin w = 3; wa = fencei_addr; end
    wa = wa & 32'hFFFF_FFFC;
    if (rst) begin
      m_pend = 0; m_drain = 0; m_addr = '0; m_src = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (m_pend) begin
      if (w >= 0 && w < m_src) begin
        m_src = w; m_addr = wa;
      end else if (ready) begin
        m_pend = 0;
        m_drain = DRAIN_CYC;
        if (m_cnt[m_src] < 64'hFFFF_FFFF) m_cnt[m_src]++;
      end
    end else if (m_drain > 0) begin
      if (w == 0 || w == 1) begin
        m_pend = 1; m_drain = 0; m_src = w; m_addr = wa;
      end else begin
        m_drain--;
      end
    end else if (w >= 0) begin
      m_pend = 1; m_src = w; m_addr = wa;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      int eh;
      eh = m_pend ? ((stall == 0) ? 1 : int'(stall)) : int'(stall);
      chk("m.jump_flag", {31'd0, jump_flag}, {31'd0, m_pend});
      chk("m.jump_addr", jump_addr, m_addr);
      chk("m.hold_flag", {29'd0, hold_flag}, eh);
      chk("m.flush", {31'd0, flush}, (m_drain > 0) ? 32'd1 : 32'd0);
      chk("m.src", {30'd0, src}, m_src);
      chk("m.busy", {31'd0, busy}, (m_pend || m_drain > 0) ? 32'd1 : 32'd0);
`ifdef REDIRECT_PERF_EN
      for (int i = 0; i < 4; i++) chk("m.perf", perf[32*i +: 32], m_cnt[i][31:0]);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_req();
    trap_req = 0; mret_req = 0; br_req = 0; fencei_req = 0;
  endtask

  task automatic accept_and_drain();
    ready = 1; tick();
    ready = 0; tick(); tick();
  endtask

  initial begin
    rst = 1; clr_req(); ready = 0; stall = 0;
    trap_addr = 0; mret_addr = 0; br_addr = 0; fencei_addr = 0;
    tick(); tick();
    chk_en = 1;
    chk("rst.jump_flag", {31'd0, jump_flag}, 0);
    chk("rst.jump_addr", jump_addr, 0);
    chk("rst.flush", {31'd0, flush}, 0);
    chk("rst.src", {30'd0, src}, 0);
    chk("rst.busy", {31'd0, busy}, 0);
    rst = 0;

    // 1: branch accepted immediately, then two flush cycles
    br_req = 1; br_addr = 32'h100; ready = 1; tick();
    chk("t1.flag", {31'd0, jump_flag}, 1);
    chk("t1.addr", jump_addr, 32'h100);
    chk("t1.src", {30'd0, src}, 2);
    chk("t1.model_addr", m_addr, 32'h100);
    chk("t1.hold", {29'd0, hold_flag}, 1);
    clr_req(); tick();
    chk("t1.flag_drop", {31'd0, jump_flag}, 0);
    chk("t1.flush1", {31'd0, flush}, 1);
    ready = 0; tick();
    chk("t1.flush2", {31'd0, flush}, 1);
    tick();
    chk("t1.flush_end", {31'd0, flush}, 0);
    chk("t1.busy_end", {31'd0, busy}, 0);

    // 2: trap beats branch in the same cycle
    trap_req = 1; trap_addr = 32'h80; br_req = 1; br_addr = 32'h200; tick();
    chk("t2.addr", jump_addr, 32'h80);
    chk("t2.src", {30'd0, src}, 0);
    chk("t2.model_src", m_src, 0);
    clr_req(); accept_and_drain();
    chk("t2.idle", {31'd0, busy}, 0);

    // 3: held redirect, preempted by mret
    br_req = 1; br_addr = 32'h300; tick();
    clr_req(); tick(); tick();
    chk("t3.flag_held", {31'd0, jump_flag}, 1);
    chk("t3.addr_held", jump_addr, 32'h300);
    chk("t3.hold_min", {29'd0, hold_flag}, 1);
    mret_req = 1; mret_addr = 32'h400; tick();
    chk("t3.addr_mret", jump_addr, 32'h400);
    chk("t3.src_mret", {30'd0, src}, 1);
    clr_req(); stall = 3; tick();
    chk("t3.hold_stall", {29'd0, hold_flag}, 3);
    stall = 0; ready = 1; tick();
    chk("t3.accepted", {31'd0, flush}, 1);
    ready = 0;

    // 4: fence.i dropped in drain, trap cuts drain short
    fencei_req = 1; fencei_addr = 32'h500; tick();
    chk("t4.fencei_drop", {31'd0, flush}, 1);
    chk("t4.src_kept", {30'd0, src}, 1);
    chk("t4.no_jump", {31'd0, jump_flag}, 0);
    clr_req(); trap_req = 1; trap_addr = 32'h80; tick();
    chk("t4.trap_flag", {31'd0, jump_flag}, 1);
    chk("t4.trap_flush", {31'd0, flush}, 0);
    chk("t4.trap_addr", jump_addr, 32'h80);
    clr_req(); accept_and_drain();

    // 5: reset while issuing discards the redirect
    br_req = 1; br_addr = 32'h600; tick();
    chk("t5.flag", {31'd0, jump_flag}, 1);
    clr_req(); rst = 1; tick();
    chk("t5.rst_flag", {31'd0, jump_flag}, 0);
    chk("t5.rst_busy", {31'd0, busy}, 0);
    rst = 0; ready = 1; tick();
    chk("t5.no_issue", {31'd0, jump_flag}, 0);
    chk("t5.no_flush", {31'd0, flush}, 0);
    ready = 0;

    // 6: low address bits forced to zero
    br_req = 1; br_addr = 32'h103; tick();
    chk("t6.align", jump_addr, 32'h100);
    chk("t6.model_align", m_addr, 32'h100);
    clr_req(); accept_and_drain();
`ifdef REDIRECT_PERF_EN
    for (int k = 0; k < 2; k++) begin
      br_req = 1; br_addr = 32'h700; tick();
      clr_req(); accept_and_drain();
    end
    chk("t6.perf_br", perf[95:64], 3);
    chk("t6.model_perf_br", m_cnt[2][31:0], 3);
`endif

    // Random traffic checked cycle-by-cycle against the model
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      trap_req    = ($urandom_range(0, 7) == 0);
      mret_req    = ($urandom_range(0, 7) == 0);
      br_req      = ($urandom_range(0, 4) == 0);
      fencei_req  = ($urandom_range(0, 5) == 0);
      trap_addr   = $urandom;
      mret_addr   = $urandom;
      br_addr     = $urandom;
      fencei_addr = $urandom;
      ready       = ($urandom_range(0, 2) != 0);
      stall       = 3'($urandom_range(0, 3));
      tick();
    end
    rst = 0; clr_req();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
